keccak_squeeze_unit: RTL and testbench

KECCAK_SQUEEZE_UNIT -- requirements
Module: keccak_squeeze_unit

---
 rtl/keccak_pkg.sv | 38 +++
 rtl/keccak_squeeze_unit_if.sv | 13 +
 rtl/keccak_rate_word_sel.sv | 37 +++
 rtl/keccak_squeeze_unit.sv | 192 +++++++++++++++++++
 tb/tb_keccak_squeeze_unit.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/keccak_pkg.sv
// Shared constants, mode/FSM encodings and rate lookup for the Keccak squeeze path.
package keccak_pkg;

  localparam int DWIDTH         = 256;
  localparam int OUT_LEN_WIDTH  = 16;
  localparam int MODE_SEL_WIDTH = 2;
  localparam int STATE_WIDTH    = 1600;
  localparam int RATE_MAX_BYTES = 168;
  localparam int RATE_PTR_WIDTH = 8;

  typedef enum logic [MODE_SEL_WIDTH-1:0] {
    SHA3_256 = 2'd0,
    SHA3_512 = 2'd1,
    SHAKE128 = 2'd2,
    SHAKE256 = 2'd3
  } keccak_mode_e;

  typedef enum logic [1:0] {
    SQ_IDLE      = 2'd0,
    SQ_EMIT      = 2'd1,
    SQ_PERM_WAIT = 2'd2
  } squeeze_state_e;

  localparam logic [RATE_PTR_WIDTH-1:0] RATE_SHA3_256 = 8'd136;
  localparam logic [RATE_PTR_WIDTH-1:0] RATE_SHA3_512 = 8'd72;
  localparam logic [RATE_PTR_WIDTH-1:0] RATE_SHAKE128 = 8'd168;
  localparam logic [RATE_PTR_WIDTH-1:0] RATE_SHAKE256 = 8'd136;

  function automatic logic [RATE_PTR_WIDTH-1:0] rate_bytes(input keccak_mode_e m);
    case (m)
      SHA3_256: return RATE_SHA3_256;
      SHA3_512: return RATE_SHA3_512;
      SHAKE128: return RATE_SHAKE128;
      default:  return RATE_SHAKE256;
    endcase
  endfunction

endpackage

// File: rtl/keccak_squeeze_unit_if.sv
// Output byte stream of the squeeze unit (AXI-Stream style, tkeep per byte).
interface keccak_squeeze_unit_if #(
  parameter int DWIDTH = keccak_pkg::DWIDTH
);
  logic [DWIDTH-1:0]   tdata;
  logic [DWIDTH/8-1:0] tkeep;
  logic                tvalid;
  logic                tlast;
  logic                tready;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/keccak_rate_word_sel.sv
// Forms one output beat: carry bytes first, then rate bytes starting at rate_ptr.
module keccak_rate_word_sel #(
  parameter int BEAT_BYTES  = keccak_pkg::DWIDTH / 8,
  parameter int RATE_BYTES  = keccak_pkg::RATE_MAX_BYTES,
  parameter int CARRY_BYTES = BEAT_BYTES - 1,
  parameter int PW          = keccak_pkg::RATE_PTR_WIDTH,
  parameter int CW          = $clog2(BEAT_BYTES)
) (
  input  logic [RATE_BYTES*8-1:0]  rate_buf,
  input  logic [PW-1:0]            rate_ptr,
  input  logic [CARRY_BYTES*8-1:0] carry,
  input  logic [CW-1:0]            carry_len,
  output logic [BEAT_BYTES*8-1:0]  word
);

  logic [7:0] rb [RATE_BYTES];

  for (genvar i = 0; i < RATE_BYTES; i++) begin : g_rb
    assign rb[i] = rate_buf[8*i +: 8];
  end

  for (genvar k = 0; k < BEAT_BYTES; k++) begin : g_byte
    logic [PW:0] idx;
    logic [7:0]  rate_b;
    logic [7:0]  b;
    // Rate bytes shift up by carry_len so the two sources abut with no gap.
    assign idx    = (PW+1)'(rate_ptr) + (PW+1)'(k) - (PW+1)'(carry_len);
    assign rate_b = (idx < (PW+1)'(RATE_BYTES)) ? rb[idx[PW-1:0]] : 8'h00;
    if (k < CARRY_BYTES) begin : g_carry
      assign b = (CW'(k) < carry_len) ? carry[8*k +: 8] : rate_b;
    end else begin : g_rate
      assign b = rate_b;
    end
    assign word[8*k +: 8] = b;
  end

endmodule

// File: rtl/keccak_squeeze_unit.sv
// Keccak squeeze stage: streams digest/XOF bytes from the rate, requesting permutations as needed.
// Optional KECCAK_SQUEEZE_ABORT_EN adds abort_i to drop an in-flight transfer.
module keccak_squeeze_unit #(
  parameter int DWIDTH        = keccak_pkg::DWIDTH,
  parameter int OUT_LEN_WIDTH = keccak_pkg::OUT_LEN_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start_i,
  input  logic [keccak_pkg::MODE_SEL_WIDTH-1:0] mode_i,
  input  logic [OUT_LEN_WIDTH-1:0]              out_len_i,
  input  logic [keccak_pkg::STATE_WIDTH-1:0]    state_i,
  output logic                                  perm_req_o,
  input  logic                                  perm_done_i,
`ifdef KECCAK_SQUEEZE_ABORT_EN
  input  logic                                  abort_i,
`endif
  output logic                                  busy_o,
  output logic                                  done_o,
  keccak_squeeze_unit_if.master                 m_axis
);
  import keccak_pkg::*;

  localparam int BEAT_BYTES  = DWIDTH / 8;
  localparam int NW          = $clog2(BEAT_BYTES + 1);
  localparam int CW          = $clog2(BEAT_BYTES);
  localparam int PW          = RATE_PTR_WIDTH;
  localparam int CARRY_BYTES = BEAT_BYTES - 1;
  localparam int CARRY_WIDTH = CARRY_BYTES * 8;
  localparam int RATE_W      = RATE_MAX_BYTES * 8;

  squeeze_state_e           fsm;
  logic [RATE_W-1:0]        rate_buf;
  logic [PW-1:0]            rate_len;
  logic [PW-1:0]            rate_ptr;
  logic [CARRY_WIDTH-1:0]   carry;
  logic [CW-1:0]            carry_len;
  logic [OUT_LEN_WIDTH-1:0] remaining;

  logic [RATE_W-1:0]        sel_src;
  logic [PW-1:0]            sel_ptr;
  logic [CW-1:0]            sel_clen;
  logic [OUT_LEN_WIDTH-1:0] sel_rem;
  logic [OUT_LEN_WIDTH-1:0] start_len;
  logic [DWIDTH-1:0]        win;
  logic [DWIDTH-1:0]        ld_data;
  logic [BEAT_BYTES-1:0]    ld_keep;
  logic [NW-1:0]            ld_n;
  logic                     ld_last;
  logic [PW-1:0]            unread;
  logic                     need_perm;
  logic                     load_beat;
  logic                     unused_state;

  // Only the largest rate (SHAKE128) of the state is ever read.
  assign unused_state = ^state_i[STATE_WIDTH-1:RATE_W];

  always_comb begin
    start_len = out_len_i;
    case (keccak_mode_e'(mode_i))
      SHA3_256: start_len = OUT_LEN_WIDTH'(32);
      SHA3_512: start_len = OUT_LEN_WIDTH'(64);
      default:  start_len = out_len_i;
    endcase
  end

  // The first beat after start or after a permutation is cut straight from state_i,
  // so tvalid rises one cycle after the event instead of two.
  assign sel_src   = (fsm == SQ_EMIT) ? rate_buf : state_i[RATE_W-1:0];
  assign sel_ptr   = (fsm == SQ_EMIT) ? rate_ptr : '0;
  assign sel_clen  = (fsm == SQ_PERM_WAIT) ? carry_len : '0;
  assign sel_rem   = (fsm == SQ_IDLE) ? start_len : remaining;
  assign ld_last   = sel_rem <= OUT_LEN_WIDTH'(BEAT_BYTES);
  assign ld_n      = ld_last ? NW'(sel_rem) : NW'(BEAT_BYTES);
  assign unread    = rate_len - rate_ptr;
  assign need_perm = PW'(ld_n) > unread;

  keccak_rate_word_sel #(
    .BEAT_BYTES  (BEAT_BYTES),
    .RATE_BYTES  (RATE_MAX_BYTES),
    .CARRY_BYTES (CARRY_BYTES),
    .PW          (PW),
    .CW          (CW)
  ) u_word_sel (
    .rate_buf  (sel_src),
    .rate_ptr  (sel_ptr),
    .carry     (carry),
    .carry_len (sel_clen),
    .word      (win)
  );

  always_comb begin
    ld_keep = '0;
    ld_data = '0;
    for (int k = 0; k < BEAT_BYTES; k++) begin
      ld_keep[k]        = NW'(k) < ld_n;
      ld_data[8*k +: 8] = ld_keep[k] ? win[8*k +: 8] : 8'h00;
    end
  end

  always_comb begin
    load_beat = 1'b0;
    case (fsm)
      SQ_IDLE:      load_beat = start_i && (start_len != '0);
      SQ_EMIT:      load_beat = m_axis.tready && !m_axis.tlast && !need_perm;
      SQ_PERM_WAIT: load_beat = perm_done_i;
      default:      load_beat = 1'b0;
    endcase
`ifdef KECCAK_SQUEEZE_ABORT_EN
    if (abort_i && fsm != SQ_IDLE) load_beat = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm           <= SQ_IDLE;
      rate_buf      <= '0;
      rate_len      <= '0;
      rate_ptr      <= '0;
      carry         <= '0;
      carry_len     <= '0;
      remaining     <= '0;
      m_axis.tdata  <= '0;
      m_axis.tkeep  <= '0;
      m_axis.tvalid <= 1'b0;
      m_axis.tlast  <= 1'b0;
      perm_req_o    <= 1'b0;
      done_o        <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      perm_req_o <= 1'b0;
      done_o     <= 1'b0;
      case (fsm)
        SQ_IDLE: if (start_i) begin
          if (start_len == '0) begin
            done_o <= 1'b1;
          end else begin
            rate_buf  <= state_i[RATE_W-1:0];
            rate_len  <= rate_bytes(keccak_mode_e'(mode_i));
            carry_len <= '0;
            busy_o    <= 1'b1;
            fsm       <= SQ_EMIT;
          end
        end
        SQ_EMIT: if (m_axis.tready) begin
          if (m_axis.tlast) begin
            m_axis.tdata  <= '0;
            m_axis.tkeep  <= '0;
            m_axis.tvalid <= 1'b0;
            m_axis.tlast  <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b1;
            fsm           <= SQ_IDLE;
          end else if (need_perm) begin
            // Park the rate tail; it leads the first beat after the permutation.
            carry         <= win[CARRY_WIDTH-1:0];
            carry_len     <= CW'(unread);
            m_axis.tvalid <= 1'b0;
            perm_req_o    <= 1'b1;
            fsm           <= SQ_PERM_WAIT;
          end
        end
        SQ_PERM_WAIT: if (perm_done_i) begin
          rate_buf  <= state_i[RATE_W-1:0];
          carry_len <= '0;
          fsm       <= SQ_EMIT;
        end
        default: fsm <= SQ_IDLE;
      endcase
`ifdef KECCAK_SQUEEZE_ABORT_EN
      if (abort_i && fsm != SQ_IDLE) begin
        m_axis.tvalid <= 1'b0;
        m_axis.tlast  <= 1'b0;
        perm_req_o    <= 1'b0;
        done_o        <= 1'b0;
        busy_o        <= 1'b0;
        carry_len     <= '0;
        fsm           <= SQ_IDLE;
      end
`endif
      if (load_beat) begin
        m_axis.tdata  <= ld_data;
        m_axis.tkeep  <= ld_keep;
        m_axis.tlast  <= ld_last;
        m_axis.tvalid <= 1'b1;
        rate_ptr      <= sel_ptr + PW'(ld_n) - PW'(sel_clen);
        remaining     <= sel_rem - OUT_LEN_WIDTH'(ld_n);
      end
    end
  end

endmodule

// File: tb/tb_keccak_squeeze_unit.sv
// Randomized bench: expected output is the concatenated rate bytes of successive states.
module tb_keccak_squeeze_unit;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [1:0]    mode_i;
  logic [15:0]   out_len_i;
  logic [1599:0] state_i;
  logic          perm_req_o;
  logic          perm_done_i;
  logic          busy_o;
  logic          done_o;
`ifdef KECCAK_SQUEEZE_ABORT_EN
  logic          abort_i;
`endif

  keccak_squeeze_unit_if #(.DWIDTH(256)) axis ();

  keccak_squeeze_unit #(.DWIDTH(256), .OUT_LEN_WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .mode_i      (mode_i),
    .out_len_i   (out_len_i),
    .state_i     (state_i),
    .perm_req_o  (perm_req_o),
    .perm_done_i (perm_done_i),
`ifdef KECCAK_SQUEEZE_ABORT_EN
    .abort_i     (abort_i),
`endif
    .busy_o      (busy_o),
    .done_o      (done_o),
    .m_axis      (axis)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [1599:0] st [16];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rate_of(input int m);
    case (m)
      0:       return 136;
      1:       return 72;
      2:       return 168;
      default: return 136;
    endcase
  endfunction

  function automatic logic [1599:0] rand1600();
    logic [1599:0] r;
    for (int w = 0; w < 50; w++) r[32*w +: 32] = $urandom;
    return r;
  endfunction

  // Byte i of the output stream = byte (i mod rate) of the (i div rate)-th state.
  function automatic logic [7:0] exp_byte(input int i, input int rate);
    logic [1599:0] s;
    s = st[i / rate];
    return s[8*(i % rate) +: 8];
  endfunction

  // mid_act: 0 = run to completion, 1 = reset on first perm_req, 2 = abort during beat 2
  task automatic run(input int mode, input int olen, input int hold0, input int stall_pct,
                     input int mid_act);
    int rate, len, nbeats, nperm, nb;
    int beats, perms, cyc, last_ret, pdone_cyc, pend_dly;
    bit pend, hold, fin;
    logic [255:0] sd, exp_d, obs_d;
    logic [31:0]  sk, exp_k;
    logic         sl;
    rate   = rate_of(mode);
    len    = (mode == 0) ? 32 : (mode == 1) ? 64 : olen;
    nbeats = (len + 31) / 32;
    nperm  = (len == 0) ? 0 : (len - 1) / rate;
    beats = 0; perms = 0; cyc = 0; last_ret = 0; pdone_cyc = -10; pend_dly = 0;
    pend = 0; hold = 0; fin = 0;
    sd = '0; sk = '0; sl = 0;
    for (int j = 0; j < 16; j++) st[j] = rand1600();

    @(negedge clk);
    state_i = st[0]; mode_i = mode[1:0]; out_len_i = olen[15:0];
    start_i = 1'b1; axis.tready = 1'b0; perm_done_i = 1'b0;

    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (hold) begin
        chk("hold_data", axis.tdata, sd);
        chk("hold_keep", axis.tkeep, sk);
        chk("hold_last", axis.tlast, sl);
      end
      hold = 0;
      if (cyc == 1) chk("valid_after_start", axis.tvalid, len > 0);
      if (cyc == pdone_cyc + 1) chk("valid_after_perm_done", axis.tvalid, 1'b1);
      if (done_o) begin
        chk("done_latency", cyc, last_ret + 1);
        chk("busy_at_done", busy_o, 1'b0);
        chk("beat_count", beats, nbeats);
        fin = 1;
        break;
      end
      if (perm_req_o) begin
        perms++;
        pend = 1;
        pend_dly = $urandom_range(0, 3);
        if (mid_act == 1) begin
          #2 rst = 1'b1;
          #1 chk("rst_outputs", {axis.tvalid, axis.tlast, axis.tkeep, axis.tdata,
                                 perm_req_o, done_o, busy_o}, '0);
          start_i = 1'b0; perm_done_i = 1'b0;
          @(negedge clk);
          rst = 1'b0;
          fin = 1;
          break;
        end
      end
`ifdef KECCAK_SQUEEZE_ABORT_EN
      if (mid_act == 2 && beats == 2 && axis.tvalid) begin
        abort_i = 1'b1; axis.tready = 1'b0; start_i = 1'b0; perm_done_i = 1'b0;
        @(negedge clk);
        abort_i = 1'b0;
        chk("abort_tvalid", axis.tvalid, 1'b0);
        chk("abort_busy", busy_o, 1'b0);
        chk("abort_done", done_o, 1'b0);
        @(negedge clk);
        chk("abort_no_done", done_o, 1'b0);
        fin = 1;
        break;
      end
`endif
      // Start while busy must be ignored; so must stray perm_done outside a request.
      start_i = busy_o ? 1'($urandom_range(0, 1)) : 1'b0;
      if (busy_o) begin
        mode_i    = 2'($urandom);
        out_len_i = 16'($urandom);
      end
      perm_done_i = 1'b0;
      state_i     = rand1600();
      if (pend) begin
        if (pend_dly == 0) begin
          perm_done_i = 1'b1;
          state_i     = st[(perms < 16) ? perms : 15];
          pend        = 0;
          pdone_cyc   = cyc;
        end else pend_dly--;
      end else if ($urandom_range(0, 7) == 0) perm_done_i = 1'b1;

      if (axis.tvalid && beats == 0 && hold0 > 0) begin
        axis.tready = 1'b0;
        hold0--;
      end else axis.tready = ($urandom_range(0, 99) >= stall_pct);

      if (axis.tvalid && axis.tready) begin
        chk("beat_in_range", beats < nbeats, 1'b1);
        if (beats < nbeats) begin
          nb = len - 32 * beats;
          if (nb > 32) nb = 32;
          exp_d = '0; exp_k = '0; obs_d = '0;
          for (int k = 0; k < 32; k++) begin
            if (k < nb) begin
              exp_d[8*k +: 8] = exp_byte(32 * beats + k, rate);
              exp_k[k]        = 1'b1;
              obs_d[8*k +: 8] = axis.tdata[8*k +: 8];
            end
          end
          chk("beat_data", obs_d, exp_d);
          chk("beat_keep", axis.tkeep, exp_k);
          chk("beat_last", axis.tlast, beats == nbeats - 1);
        end
        beats++;
        last_ret = cyc;
      end else if (axis.tvalid) begin
        hold = 1; sd = axis.tdata; sk = axis.tkeep; sl = axis.tlast;
      end
    end

    start_i = 1'b0; perm_done_i = 1'b0;
    if (!fin) chk("timeout", 1'b0, 1'b1);
    else if (mid_act == 0) begin
      chk("perm_count", perms, nperm);
      @(negedge clk);
      chk("done_single_pulse", done_o, 1'b0);
      chk("idle_tvalid", axis.tvalid, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; mode_i = '0; out_len_i = '0; state_i = '0;
    perm_done_i = 1'b0; axis.tready = 1'b0;
`ifdef KECCAK_SQUEEZE_ABORT_EN
    abort_i = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_tvalid", axis.tvalid, 1'b0);
    chk("reset_tlast", axis.tlast, 1'b0);
    chk("reset_tkeep", axis.tkeep, '0);
    chk("reset_tdata", axis.tdata, '0);
    chk("reset_perm_req", perm_req_o, 1'b0);
    chk("reset_done", done_o, 1'b0);
    chk("reset_busy", busy_o, 1'b0);
    rst = 1'b0;

    run(0, 77, 0, 0, 0);     // SHA3_256, single beat
    run(1, 5, 3, 0, 0);      // SHA3_512, beat 0 stalled 3 cycles
    run(2, 200, 0, 0, 0);    // SHAKE128 across one permutation
    run(3, 0, 0, 0, 0);      // zero-length SHAKE
    run(2, 168, 0, 30, 0);   // exactly one rate, no permutation
    run(3, 137, 1, 25, 0);   // one byte past the rate
    run(2, 200, 0, 0, 1);    // reset while waiting for the permutation
    run(2, 200, 0, 20, 0);   // clean restart after that reset
    for (int i = 0; i < 12; i++)
      run($urandom_range(0, 3), $urandom_range(0, 600), $urandom_range(0, 4),
          $urandom_range(0, 50), 0);
`ifdef KECCAK_SQUEEZE_ABORT_EN
    run(3, 300, 0, 0, 2);
    run(1, 0, 0, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
